// File: rtl/iob_eth_mii_rx_seq.sv
// MII receive sequencer: strips preamble/SFD, packs nibbles into bytes for a frame buffer,
// then offers each captured frame with length and status until the consumer acknowledges it.
module iob_eth_mii_rx_seq #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned MAX_BYTES  = 1518,
    parameter int unsigned MIN_BYTES  = 64,
    parameter int unsigned IFG_CYCLES = 10
) (
    input  logic              RX_CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        RX_DATA,
    input  logic              RX_DV,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              frame_ready,
    output logic [15:0]       frame_len,
    output logic [1:0]        frame_err,
    input  logic              frame_ack,
    output logic [15:0]       drop_cnt
);

    localparam logic [15:0] MaxBytes = 16'(MAX_BYTES);
    localparam logic [15:0] MinBytes = 16'(MIN_BYTES);
    localparam logic [15:0] IfgLast  = 16'(IFG_CYCLES - 1);

    localparam logic [1:0] ErrOk       = 2'd0;
    localparam logic [1:0] ErrRunt     = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;
    localparam logic [1:0] ErrOdd      = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StData,
        StDrain,
        StGap,
        StReady
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         byte_cnt_q, byte_cnt_d;
    logic [3:0]          nib_q, nib_d;
    logic                pend_q, pend_d;
    logic [15:0]         gap_q, gap_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          err_q, err_d;
    logic [15:0]         drop_q, drop_d;
    logic                dv_q;
    logic                dv_rise;

    assign dv_rise = RX_DV && !dv_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        nib_d      = nib_q;
        pend_d     = pend_q;
        gap_d      = gap_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        err_d      = err_q;
        drop_d     = drop_q;

        // Any frame that starts while one is waiting to be offered or consumed is lost.
        if ((state_q == StGap || state_q == StReady) && dv_rise && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                if (enable && RX_DV) begin
                    byte_cnt_d = 16'd0;
                    pend_d     = 1'b0;
                    if (RX_DATA == 4'h5) begin
                        state_d = StPre;
                    end else if (RX_DATA == 4'hD) begin
                        state_d = StData;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StPre: begin
                if (!RX_DV) begin
                    state_d = StIdle;
                end else if (RX_DATA == 4'hD) begin
                    state_d = StData;
                end else if (RX_DATA != 4'h5) begin
                    state_d = StDrain;
                end
            end
            StData: begin
                if (!RX_DV) begin
                    len_d   = byte_cnt_q;
                    gap_d   = 16'd0;
                    state_d = StGap;
                    if (pend_q) begin
                        err_d = ErrOdd;
                    end else if (byte_cnt_q < MinBytes) begin
                        err_d = ErrRunt;
                    end else begin
                        err_d = ErrOk;
                    end
                end else if (!pend_q) begin
                    nib_d  = RX_DATA;
                    pend_d = 1'b1;
                end else begin
                    pend_d = 1'b0;
                    if (byte_cnt_q == MaxBytes) begin
                        len_d   = byte_cnt_q;
                        err_d   = ErrOverflow;
                        state_d = StDrain;
                    end else begin
                        we_d       = 1'b1;
                        addr_d     = byte_cnt_q[ADDR_W-1:0];
                        wdata_d    = {RX_DATA, nib_q};
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                if (!RX_DV) begin
                    gap_d   = 16'd0;
                    state_d = (err_q != ErrOk) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (gap_q == IfgLast) begin
                    state_d = StReady;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            StReady: begin
                // Clearing status keeps a post-ack flush through DRAIN from re-offering.
                if (frame_ack) begin
                    err_d   = ErrOk;
                    state_d = RX_DV ? StDrain : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge RX_CLK or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= 16'd0;
            nib_q      <= 4'd0;
            pend_q     <= 1'b0;
            gap_q      <= 16'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'd0;
            len_q      <= 16'd0;
            err_q      <= 2'd0;
            drop_q     <= 16'd0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            nib_q      <= nib_d;
            pend_q     <= pend_d;
            gap_q      <= gap_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            dv_q       <= RX_DV;
        end
    end

    assign buf_we      = we_q;
    assign buf_addr    = addr_q;
    assign buf_wdata   = wdata_q;
    assign frame_ready = (state_q == StReady);
    assign frame_len   = len_q;
    assign frame_err   = err_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_iob_eth_mii_rx_seq.sv
// Scoreboard bench: stimulus pushes expected buffer writes and frame results, a negedge
// monitor pops and compares them as the DUT presents writes and offered frames.
module tb_iob_eth_mii_rx_seq;

    localparam int ADDR_W = 11;
    localparam int MAXB   = 80;
    localparam int MINB   = 64;
    localparam int IFG    = 10;

    logic              RX_CLK = 1'b0;
    logic              reset;
    logic              enable;
    logic [3:0]        RX_DATA;
    logic              RX_DV;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              frame_ready;
    logic [15:0]       frame_len;
    logic [1:0]        frame_err;
    logic              frame_ack;
    logic [15:0]       drop_cnt;

    iob_eth_mii_rx_seq #(
        .ADDR_W    (ADDR_W),
        .MAX_BYTES (MAXB),
        .MIN_BYTES (MINB),
        .IFG_CYCLES(IFG)
    ) dut (
        .RX_CLK     (RX_CLK),
        .reset      (reset),
        .enable     (enable),
        .RX_DATA    (RX_DATA),
        .RX_DV      (RX_DV),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .frame_ready(frame_ready),
        .frame_len  (frame_len),
        .frame_err  (frame_err),
        .frame_ack  (frame_ack),
        .drop_cnt   (drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct packed {
        logic [15:0] len;
        logic [1:0]  err;
    } fr_t;

    wr_t        wq[$];
    fr_t        fq[$];
    logic [3:0] nibs[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: only whole bytes count; bytes beyond MAXB are lost and flag overflow.
    task automatic push_model();
        int n, bytes, nwr, len, err;
        n     = nibs.size();
        bytes = n / 2;
        if (bytes > MAXB) begin
            nwr = MAXB; len = MAXB; err = 2;
        end else begin
            nwr = bytes; len = bytes;
            err = (n % 2 == 1) ? 3 : (bytes < MINB) ? 1 : 0;
        end
        for (int i = 0; i < nwr; i++) wq.push_back({ADDR_W'(i), nibs[2*i+1], nibs[2*i]});
        fq.push_back({16'(len), 2'(err)});
    endtask

    task automatic build_random(input int n);
        nibs.delete();
        for (int i = 0; i < n; i++) nibs.push_back(4'($urandom_range(0, 15)));
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic ack = 1'b0);
        @(posedge RX_CLK);
        #1;
        RX_DV     = dv;
        RX_DATA   = d;
        frame_ack = ack;
    endtask

    // en_off_at >= 0 drops enable at that data nibble; the frame must still complete.
    task automatic send_frame(input int npre, input bit expect_cap, input int en_off_at = -1);
        if (expect_cap) push_model();
        for (int i = 0; i < npre; i++) drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        for (int i = 0; i < nibs.size(); i++) begin
            if (i == en_off_at) enable = 1'b0;
            drive(1'b1, nibs[i]);
        end
        drive(1'b0, 4'h0);
    endtask

    // Called right after RX_DV is driven low: one edge to leave DATA/DRAIN, then IFG in GAP.
    task automatic wait_ready(input bit check_lat);
        int cnt = 0;
        while (frame_ready !== 1'b1 && cnt < 200) begin
            @(posedge RX_CLK);
            #1;
            cnt++;
        end
        chk("frame_offered", int'(frame_ready), 1);
        if (check_lat) chk("ifg_latency", cnt, IFG + 1);
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) begin
            @(posedge RX_CLK);
            #1;
        end
        @(posedge RX_CLK);
        #1;
        frame_ack = 1'b1;
        @(posedge RX_CLK);
        #1;
        frame_ack = 1'b0;
        chk("ready_fell_after_ack", int'(frame_ready), 0);
    endtask

    task automatic idle_check_none(input int cycles);
        repeat (cycles) begin
            @(posedge RX_CLK);
            #1;
        end
        chk("no_frame_offered", int'(frame_ready), 0);
    endtask

    // Monitor
    logic        rdy_seen = 1'b0;
    logic [15:0] held_len;
    logic [1:0]  held_err;

    always @(negedge RX_CLK) begin
        if (reset) begin
            rdy_seen = 1'b0;
        end else begin
            if (buf_we) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write addr=%0d data=%02h expected=none at %0t",
                             buf_addr, buf_wdata, $time);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", int'(buf_addr), int'(w.addr));
                    chk("wr_data", int'(buf_wdata), int'(w.data));
                end
            end
            if (frame_ready) begin
                if (!rdy_seen) begin
                    if (fq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame len=%0d err=%0d expected=none at %0t",
                                 frame_len, frame_err, $time);
                    end else begin
                        fr_t f;
                        f = fq.pop_front();
                        chk("frame_len", int'(frame_len), int'(f.len));
                        chk("frame_err", int'(frame_err), int'(f.err));
                    end
                    held_len = frame_len;
                    held_err = frame_err;
                end else begin
                    chk("len_stable", int'(frame_len), int'(held_len));
                    chk("err_stable", int'(frame_err), int'(held_err));
                end
            end
            rdy_seen = frame_ready;
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        RX_DV     = 1'b0;
        RX_DATA   = 4'h0;
        frame_ack = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
        chk("rst_buf_we", int'(buf_we), 0);
        chk("rst_buf_addr", int'(buf_addr), 0);
        chk("rst_buf_wdata", int'(buf_wdata), 0);
        chk("rst_ready", int'(frame_ready), 0);
        chk("rst_len", int'(frame_len), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        reset = 1'b0;

        // 64-byte ramp 00..3F after a full preamble
        nibs.delete();
        for (int b = 0; b < 64; b++) begin
            nibs.push_back(4'(b % 16));
            nibs.push_back(4'(b / 16));
        end
        send_frame(15, 1'b1);
        wait_ready(1'b1);
        do_ack(2);

        // Runt, odd nibble, and both sides of the MAXB boundary
        build_random(40);  send_frame(15, 1'b1); wait_ready(1'b1); do_ack(0);
        build_random(129); send_frame(15, 1'b1); wait_ready(1'b1); do_ack(1);
        build_random(160); send_frame(3, 1'b1);  wait_ready(1'b1); do_ack(0);
        build_random(161); send_frame(3, 1'b1);  wait_ready(1'b1); do_ack(0);
        build_random(162); send_frame(3, 1'b1);  wait_ready(1'b1); do_ack(0);
        build_random(200); send_frame(0, 1'b1);  wait_ready(1'b1); do_ack(3);

        // Frame arriving while one is offered is dropped; offered frame held
        build_random(140); send_frame(8, 1'b1); wait_ready(1'b1);
        build_random(100); send_frame(8, 1'b0);
        exp_drop++;
        chk("drop_cnt_1", int'(drop_cnt), exp_drop);
        chk("still_ready", int'(frame_ready), 1);

        // Ack while RX_DV high: flush rest of that frame, including its SFD
        build_random(60);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h5, 1'b1);
        drive(1'b1, 4'h5);
        chk("ready_fell_mid_stream", int'(frame_ready), 0);
        drive(1'b1, 4'hD);
        for (int i = 0; i < nibs.size(); i++) drive(1'b1, nibs[i]);
        drive(1'b0, 4'h0);
        exp_drop++;
        chk("drop_cnt_2", int'(drop_cnt), exp_drop);
        idle_check_none(IFG + 5);

        // Bad preamble is discarded, next frame captured
        drive(1'b1, 4'h5); drive(1'b1, 4'h3); drive(1'b1, 4'hD); drive(1'b1, 4'h7);
        drive(1'b0, 4'h0);
        idle_check_none(IFG + 5);
        build_random(130); send_frame(7, 1'b1); wait_ready(1'b1); do_ack(0);

        // enable low blocks capture; dropping it mid-frame does not abort
        enable = 1'b0;
        build_random(140); send_frame(7, 1'b0);
        idle_check_none(IFG + 5);
        enable = 1'b1;
        build_random(140); send_frame(7, 1'b1, 50); wait_ready(1'b1); do_ack(0);
        enable = 1'b1;
        chk("drop_cnt_3", int'(drop_cnt), exp_drop);

        // Reset after 30 data nibbles: 15 bytes written, then everything cleared
        build_random(30);
        for (int i = 0; i < 15; i++) wq.push_back({ADDR_W'(i), nibs[2*i+1], nibs[2*i]});
        for (int i = 0; i < 4; i++) drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        for (int i = 0; i < 30; i++) drive(1'b1, nibs[i]);
        drive(1'b1, 4'hA);
        @(posedge RX_CLK);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_buf_we", int'(buf_we), 0);
        chk("mid_rst_buf_addr", int'(buf_addr), 0);
        chk("mid_rst_buf_wdata", int'(buf_wdata), 0);
        chk("mid_rst_ready", int'(frame_ready), 0);
        chk("mid_rst_len", int'(frame_len), 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        chk("partial_writes_seen", wq.size(), 0);
        exp_drop = 0;
        drive(1'b1, 4'hA);
        reset = 1'b0;
        drive(1'b1, 4'hA);
        drive(1'b1, 4'hA);
        drive(1'b0, 4'h0);
        idle_check_none(IFG + 5);
        build_random(128); send_frame(15, 1'b1); wait_ready(1'b1); do_ack(0);

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            build_random($urandom_range(40, 200));
            send_frame($urandom_range(0, 15), 1'b1);
            wait_ready(1'b1);
            do_ack($urandom_range(0, 4));
        end

        repeat (3) @(posedge RX_CLK);
        #1;
        chk("writes_drained", wq.size(), 0);
        chk("frames_drained", fq.size(), 0);
        chk("drop_cnt_final", int'(drop_cnt), exp_drop);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
